// File: rtl/lsu_byte_seq_pkg.sv
// Shared definitions for the load/store byte sequencer.
//   - RV32I funct3 encodings for loads and stores
//   - FSM state encoding
//   - size decode and legality helpers used by the request decoder
package lsu_byte_seq_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STORE,
        ST_LOAD,
        ST_DRAIN,
        ST_RESP,
        ST_ERR
    } state_t;

    // Number of bytes moved by an access; 0 for an unused size code.
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Stores only exist in the signed-looking encodings; unsigned forms are load-only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW: return 1'b1;
            F3_LBU, F3_LHU:      return !we;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_seq_if.sv
// Request/response bundle between a core-side requester and the byte sequencer.
//   req_valid/req_ready   handshake, accepted when both high on a rising edge
//   req_we                1 = store, 0 = load
//   req_funct3            RV32I size/sign code
//   req_addr, req_wdata   byte address and store data
//   rsp_valid             single-cycle response pulse, no backpressure
//   rsp_rdata, rsp_err    extended load data / rejection flag
interface lsu_byte_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_byte_seq_load_extend.sv
// Combinational load-data formatter.
//   funct3    in  3    RV32I load code selecting width and sign treatment
//   bytes_in  in  4x8  little-endian bytes, byte 0 at the access address
//   data      out 32   assembled word, sign- or zero-extended
module lsu_byte_seq_load_extend
    import lsu_byte_seq_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [3:0][7:0] bytes_in,
    output logic [31:0]     data
);

    logic signed [7:0]  lo8;
    logic signed [15:0] lo16;

    always_comb begin
        lo8  = bytes_in[0];
        lo16 = {bytes_in[1], bytes_in[0]};
        data = bytes_in;
        case (funct3)
            F3_LB:   data = 32'(lo8);
            F3_LH:   data = 32'(lo16);
            F3_LBU:  data = {24'd0, bytes_in[0]};
            F3_LHU:  data = {16'd0, bytes_in[1], bytes_in[0]};
            default: data = bytes_in;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store sequencer in front of an 8-bit byte RAM with a registered read port.
// Splits one RV32I load/store into 1/2/4 little-endian byte accesses, reassembles
// and extends load data, and returns exactly one response per accepted request.
//   clk, rst_n      clock and asynchronous active-low reset
//   bus             request/response bundle (slave side)
//   mem_address     byte address to the RAM
//   mem_data_in     store byte to the RAM
//   mem_write_en    RAM write strobe, active high
//   mem_data_out    RAM read data for the address presented one cycle earlier
module lsu_byte_seq
    import lsu_byte_seq_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_byte_seq_if.slave      bus,
    output logic [31:0]        mem_address,
    output logic [7:0]         mem_data_in,
    output logic               mem_write_en,
    input  logic [7:0]         mem_data_out
);

    state_t          state, state_n;
    logic [1:0]      cnt, cnt_n;
    logic [1:0]      last, last_n;
    logic [2:0]      funct3_r, funct3_n;
    logic [31:0]     addr_r, addr_n;
    logic [31:0]     wdata_r, wdata_n;
    logic [3:0][7:0] buf_r, buf_n;

    logic            ready_n;
    logic            rsp_valid_n;
    logic            rsp_err_n;
    logic [31:0]     rsp_rdata_n;
    logic [31:0]     mem_address_n;
    logic [7:0]      mem_data_in_n;
    logic            mem_write_en_n;

    // Request decode and rejection check
    logic [2:0]      req_size;
    logic            misaligned;
    logic [32:0]     req_end;
    logic            out_of_range;
    logic            req_ok;

    always_comb begin
        req_size     = size_bytes(bus.req_funct3);
        misaligned   = (req_size == 3'd2 && bus.req_addr[0]) ||
                       (req_size == 3'd4 && bus.req_addr[1:0] != 2'b00);
        // 33-bit sum so an address near 2^32 cannot wrap back into range.
        req_end      = {1'b0, bus.req_addr} + {30'd0, req_size} - 33'd1;
        out_of_range = req_end >= 33'(ADDR_LIMIT);
        req_ok       = funct3_legal(bus.req_we, bus.req_funct3) && !misaligned && !out_of_range;
    end

    // Load assembly: the final byte is still on the RAM port during DRAIN.
    logic [3:0][7:0] load_bytes;
    logic [31:0]     load_data;

    always_comb begin
        load_bytes = buf_r;
        load_bytes[last] = mem_data_out;
    end

    lsu_byte_seq_load_extend u_extend (
        .funct3   (funct3_r),
        .bytes_in (load_bytes),
        .data     (load_data)
    );

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        last_n         = last;
        funct3_n       = funct3_r;
        addr_n         = addr_r;
        wdata_n        = wdata_r;
        buf_n          = buf_r;
        ready_n        = 1'b0;
        rsp_valid_n    = 1'b0;
        rsp_err_n      = 1'b0;
        rsp_rdata_n    = 32'd0;
        mem_address_n  = mem_address;
        mem_data_in_n  = mem_data_in;
        mem_write_en_n = 1'b0;

        case (state)
            ST_IDLE: begin
                ready_n = 1'b1;
                if (bus.req_valid && bus.req_ready) begin
                    ready_n  = 1'b0;
                    funct3_n = bus.req_funct3;
                    addr_n   = bus.req_addr;
                    wdata_n  = bus.req_wdata;
                    cnt_n    = 2'd0;
                    last_n   = 2'(req_size - 3'd1);
                    if (!req_ok) begin
                        state_n     = ST_ERR;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else if (bus.req_we) begin
                        state_n        = ST_STORE;
                        mem_address_n  = bus.req_addr;
                        mem_data_in_n  = bus.req_wdata[7:0];
                        mem_write_en_n = 1'b1;
                    end else begin
                        state_n       = ST_LOAD;
                        mem_address_n = bus.req_addr;
                    end
                end
            end
            ST_STORE: begin
                if (cnt == last) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                end else begin
                    cnt_n          = cnt + 2'd1;
                    mem_address_n  = addr_r + {30'd0, cnt_n};
                    mem_data_in_n  = 8'(wdata_r >> {cnt_n, 3'b000});
                    mem_write_en_n = 1'b1;
                end
            end
            ST_LOAD: begin
                // RAM output now reflects the address driven one cycle ago.
                if (cnt != 2'd0) begin
                    buf_n[cnt - 2'd1] = mem_data_out;
                end
                if (cnt == last) begin
                    state_n = ST_DRAIN;
                end else begin
                    cnt_n         = cnt + 2'd1;
                    mem_address_n = addr_r + {30'd0, cnt_n};
                end
            end
            ST_DRAIN: begin
                state_n     = ST_RESP;
                rsp_valid_n = 1'b1;
                rsp_rdata_n = load_data;
            end
            ST_RESP, ST_ERR: begin
                state_n = ST_IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= 2'd0;
            last          <= 2'd0;
            funct3_r      <= 3'd0;
            addr_r        <= 32'd0;
            wdata_r       <= 32'd0;
            buf_r         <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            mem_address   <= 32'd0;
            mem_data_in   <= 8'd0;
            mem_write_en  <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            last          <= last_n;
            funct3_r      <= funct3_n;
            addr_r        <= addr_n;
            wdata_r       <= wdata_n;
            buf_r         <= buf_n;
            bus.req_ready <= ready_n;
            bus.rsp_valid <= rsp_valid_n;
            bus.rsp_err   <= rsp_err_n;
            bus.rsp_rdata <= rsp_rdata_n;
            mem_address   <= mem_address_n;
            mem_data_in   <= mem_data_in_n;
            mem_write_en  <= mem_write_en_n;
        end
    end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Bench for lsu_byte_seq with a behavioural byte RAM (registered read port).
// Expected values come from a shadow memory and plain-arithmetic load/store rules.
module tb_lsu_byte_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_write_en;

    lsu_byte_seq_if bus ();

    lsu_byte_seq #(.ADDR_LIMIT(4096)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datamem: write on edge, data_out registered from the presented address
    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_write_en && mem_address < 32'd4096) ram[mem_address[11:0]] <= mem_data_in;
        mem_data_out <= ram[mem_address[11:0]];
    end

    logic [7:0] shadow [0:4095];

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         wr_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] pre_addr;

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int n;
        n = ref_size(f3);
        if (n == 0) return 1;
        if (we && f3 > 3'd2) return 1;
        if ((addr % n) != 0) return 1;
        if (longint'(addr) + longint'(n) > 64'd4096) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        longint v;
        int     n;
        n = ref_size(f3);
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(shadow[int'(addr) + i]) << (8 * i));
        if (f3 <= 3'd1 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // ---------------- request driver ----------------
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                          output int lat, output bit ok);
        int guard;
        ok = 1;
        wr_q.delete();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        pre_addr = mem_address;
        if (guard >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%h ready=%b required ready=1", addr, bus.req_ready);
            bus.req_valid = 1'b0;
            ok = 0; rdata = 0; err = 0; lat = -1;
            return;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 1;
        forever begin
            if (mem_write_en === 1'b1) wr_q.push_back('{a: mem_address, d: mem_data_in});
            if (bus.rsp_valid === 1'b1 || lat >= 30) break;
            @(negedge clk);
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (bus.rsp_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL rsp_timeout addr=%h got no rsp_valid within 30 cycles", addr);
            ok = 0;
        end
    endtask

    // Issue one request and check everything the model predicts for it.
    task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rdata, exp_rdata, rsp_addr;
        logic        err, exp_err;
        int          lat, exp_lat, n;
        bit          ok;
        exp_err = ref_err(we, f3, addr);
        n = ref_size(f3);
        exp_rdata = (exp_err || we) ? 32'd0 : ref_load(f3, addr);
        exp_lat = exp_err ? 1 : (we ? n + 1 : n + 2);
        do_req(we, f3, addr, wd, rdata, err, lat, ok);
        if (!ok) return;
        rsp_addr = mem_address;
        total++;
        if (err !== exp_err) begin bad++; $display("FAIL %s err got=%b want=%b", name, err, exp_err); end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat); end
        total++;
        if (rdata !== exp_rdata) begin bad++; $display("FAIL %s rdata got=%h want=%h", name, rdata, exp_rdata); end
        if (exp_err || !we) begin
            total++;
            if (wr_q.size() != 0) begin bad++; $display("FAIL %s writes got=%0d want=0", name, wr_q.size()); end
        end
        if (exp_err) begin
            total++;
            if (rsp_addr !== pre_addr) begin bad++; $display("FAIL %s mem_address got=%h want=%h", name, rsp_addr, pre_addr); end
        end
        if (!exp_err && we) begin
            total++;
            if (wr_q.size() != n) begin
                bad++; $display("FAIL %s write_count got=%0d want=%0d", name, wr_q.size(), n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    total++;
                    if (wr_q[k].a !== addr + 32'(k) || wr_q[k].d !== 8'(wd >> (8 * k))) begin
                        bad++;
                        $display("FAIL %s write%0d got=%h:%h want=%h:%h", name, k, wr_q[k].a, wr_q[k].d,
                                 addr + 32'(k), 8'(wd >> (8 * k)));
                    end
                end
            end
            for (int k = 0; k < n; k++) shadow[int'(addr) + k] = 8'(wd >> (8 * k));
        end
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL %s rsp_pulse got=%b want=0", name, bus.rsp_valid); end
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL %s ready_after got=%b want=1", name, bus.req_ready); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b want=0", bus.rsp_err); end
        total++; if (bus.rsp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", bus.rsp_rdata); end
        total++; if (mem_address !== 32'd0) begin bad++; $display("FAIL rst_mem_address got=%h want=0", mem_address); end
        total++; if (mem_data_in !== 8'd0) begin bad++; $display("FAIL rst_mem_data_in got=%h want=0", mem_data_in); end
        total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL rst_write_en got=%b want=0", mem_write_en); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_release got=%b want=0", bus.req_ready); end
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_first_edge got=%b want=1", bus.req_ready); end
    endtask

    task automatic test_store_word();
        run_req("sw_3fc", 1'b1, 3'b010, 32'h3FC, 32'hA1B2C3D4);
    endtask

    task automatic test_loads();
        run_req("lw_3fc", 1'b0, 3'b010, 32'h3FC, 32'd0);
        run_req("lb_3ff", 1'b0, 3'b000, 32'h3FF, 32'd0);
        run_req("lbu_3ff", 1'b0, 3'b100, 32'h3FF, 32'd0);
        run_req("lh_3fe", 1'b0, 3'b001, 32'h3FE, 32'd0);
        run_req("lhu_3fe", 1'b0, 3'b101, 32'h3FE, 32'd0);
    endtask

    task automatic test_errors();
        run_req("sh_odd", 1'b1, 3'b001, 32'h001, 32'hDEADBEEF);
        run_req("lw_mis", 1'b0, 3'b010, 32'h002, 32'd0);
        run_req("f3_011", 1'b0, 3'b011, 32'h000, 32'd0);
        run_req("sbu_illegal", 1'b1, 3'b100, 32'h000, 32'h55);
        run_req("sw_ffc", 1'b1, 3'b010, 32'hFFC, 32'h8899AABB);
        run_req("lw_ffc", 1'b0, 3'b010, 32'hFFC, 32'd0);
        run_req("lh_fff", 1'b0, 3'b001, 32'hFFF, 32'd0);
        run_req("lb_1000", 1'b0, 3'b000, 32'h1000, 32'd0);
        run_req("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFC, 32'h12345678);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        we;
        for (int i = 0; i < 8; i++) run_req("init", 1'b1, 3'b010, 32'h200 + 32'(4 * i), $urandom);
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       addr = 32'hFFC + 32'($urandom_range(0, 5));
                1:       addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                default: addr = 32'h200 + 32'($urandom_range(0, 31));
            endcase
            run_req("rand", we, f3, addr, $urandom);
        end
    endtask

    task automatic test_reset_mid_store();
        int guard;
        int pulses;
        run_req("preload_100", 1'b1, 3'b010, 32'h100, 32'h00000000);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h100; bus.req_wdata = 32'h11223344;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        total++;
        if (guard >= 50) begin bad++; $display("FAIL mid_accept ready=%b want=1", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (mem_write_en !== 1'b1 || mem_address !== 32'h102) begin
            bad++; $display("FAIL mid_third_byte we=%b addr=%h want we=1 addr=00000102", mem_write_en, mem_address);
        end
        rst_n = 1'b0;
        #1;
        total++; if (mem_write_en !== 1'b0) begin bad++; $display("FAIL mid_we_drop got=%b want=0", mem_write_en); end
        pulses = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_rsp got=%0d want=0", pulses); end
        shadow[32'h100] = 8'h44;
        shadow[32'h101] = 8'h33;
        run_req("lw_100_after", 1'b0, 3'b010, 32'h100, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [7:0]  d [3];
        int          idx, pulses;
        bit          acc;
        for (int i = 0; i < 3; i++) begin
            a[i] = 32'h210 + 32'($urandom_range(0, 15));
            d[i] = 8'($urandom);
        end
        wr_q.delete();
        idx = 0; pulses = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = a[0]; bus.req_wdata = {24'hABCDEF, d[0]};
        for (int c = 0; c < 80 && (idx < 3 || pulses < 3); c++) begin
            if (mem_write_en === 1'b1) wr_q.push_back('{a: mem_address, d: mem_data_in});
            if (bus.rsp_valid === 1'b1) pulses++;
            acc = bus.req_valid && bus.req_ready === 1'b1;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    bus.req_addr = a[idx]; bus.req_wdata = {24'h123456, d[idx]};
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        total++; if (idx != 3) begin bad++; $display("FAIL b2b_accepts got=%0d want=3", idx); end
        total++; if (pulses != 3) begin bad++; $display("FAIL b2b_rsp_pulses got=%0d want=3", pulses); end
        total++;
        if (wr_q.size() != 3) begin
            bad++; $display("FAIL b2b_write_count got=%0d want=3", wr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wr_q[i].a !== a[i] || wr_q[i].d !== d[i]) begin
                    bad++; $display("FAIL b2b_write%0d got=%h:%h want=%h:%h", i, wr_q[i].a, wr_q[i].d, a[i], d[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) shadow[a[i]] = d[i];
        run_req("b2b_readback", 1'b0, 3'b100, a[2], 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = 8'd0;
        test_reset();
        test_store_word();
        test_loads();
        test_errors();
        test_random();
        test_reset_mid_store();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
